i2c_pcf8574_target: RTL and testbench

//  I2C target (responder) that emulates a PCF8574 8-bit quasi-bidirectional I/O expander, i.e. the LCD backpack at 7'h27.

---
 rtl/i2c_pcf8574_target_if.sv | 20 ++
 rtl/i2c_pcf8574_target.sv | 174 +++++++++++++++++
 tb/tb_i2c_pcf8574_target.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pcf8574_target_if.sv
// Local-side signals of the PCF8574 emulator: the parallel port plus activity strobes.
// wr_tick/rd_tick are single-clk strobes with no back-pressure (no ready): each is high for exactly one clk per event.
interface i2c_pcf8574_target_if;
  logic [7:0] port_in;
  logic [7:0] port_out;
  logic       wr_tick;
  logic       rd_tick;
  logic       busy;
  logic [2:0] dbg_state;

  modport slave (
    input  port_in,
    output port_out, wr_tick, rd_tick, busy, dbg_state
  );

  modport master (
    output port_in,
    input  port_out, wr_tick, rd_tick, busy, dbg_state
  );
endinterface

// File: rtl/i2c_pcf8574_target.sv
// I2C target emulating a PCF8574 I/O expander: writes land in port_out, reads return port_in.
// SCL/SDA are oversampled on clk; SCL is never stretched.
module i2c_pcf8574_target #(
  parameter logic [6:0] ADDRESS     = 7'h27,
  parameter logic [7:0] RESET_VALUE = 8'hFF
) (
  input  logic clk,
  input  logic reset,
  input  logic SCL,
  inout  wire  SDA,
  i2c_pcf8574_target_if.slave io
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_DATA  = 3'd3,
    WR_ACK   = 3'd4,
    RD_DATA  = 3'd5,
    RD_ACK   = 3'd6,
    IGNORE   = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] scl_sync_q, sda_sync_q;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] port_out_q, port_out_d;
  logic       wr_tick_q, wr_tick_d;
  logic       rd_tick_q, rd_tick_d;
  logic       busy_q, busy_d;
  logic       mack_q, mack_d;

  logic scl_rise, scl_fall, sda_rise, sda_fall, scl_edge, start_det, stop_det, sda_in;

  // Stage [1] is the synced level, stage [2] its history.
  assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
  assign sda_rise  = sda_sync_q[1] & ~sda_sync_q[2];
  assign sda_fall  = ~sda_sync_q[1] & sda_sync_q[2];
  assign scl_edge  = scl_rise | scl_fall;
  assign start_det = sda_fall & scl_sync_q[1] & ~scl_edge;
  assign stop_det  = sda_rise & scl_sync_q[1] & ~scl_edge;
  assign sda_in    = sda_sync_q[1];

  assign SDA          = sda_oe_q ? 1'b0 : 1'bz;
  assign io.port_out  = port_out_q;
  assign io.wr_tick   = wr_tick_q;
  assign io.rd_tick   = rd_tick_q;
  assign io.busy      = busy_q;
  assign io.dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    sda_oe_d   = sda_oe_q;
    port_out_d = port_out_q;
    wr_tick_d  = 1'b0;
    rd_tick_d  = 1'b0;
    busy_d     = busy_q;
    mack_d     = mack_q;
    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ADDR, WR_DATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_in};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            if (state_q == ADDR) begin
              if (shift_q[7:1] == ADDRESS) begin
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                state_d  = ADDR_ACK;
              end else begin
                state_d = IGNORE;
              end
            end else begin
              port_out_d = shift_q;
              wr_tick_d  = 1'b1;
              sda_oe_d   = 1'b1;
              state_d    = WR_ACK;
            end
          end
        end
        ADDR_ACK, RD_ACK: begin
          if (state_q == RD_ACK && scl_rise) begin
            mack_d = sda_in;
          end
          if (scl_fall) begin
            // shift_q[0] still holds R/W in ADDR_ACK; in RD_ACK the master's ACK decides.
            if ((state_q == ADDR_ACK && shift_q[0]) || (state_q == RD_ACK && !mack_q)) begin
              shift_d   = io.port_in;
              rd_tick_d = 1'b1;
              sda_oe_d  = ~io.port_in[7];
              bit_cnt_d = 4'd0;
              state_d   = RD_DATA;
            end else if (state_q == ADDR_ACK) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = WR_DATA;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = RD_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      state_q    <= IDLE;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 4'd0;
      sda_oe_q   <= 1'b0;
      port_out_q <= RESET_VALUE;
      wr_tick_q  <= 1'b0;
      rd_tick_q  <= 1'b0;
      busy_q     <= 1'b0;
      mack_q     <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], SCL};
      sda_sync_q <= {sda_sync_q[1:0], SDA};
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      sda_oe_q   <= sda_oe_d;
      port_out_q <= port_out_d;
      wr_tick_q  <= wr_tick_d;
      rd_tick_q  <= rd_tick_d;
      busy_q     <= busy_d;
      mack_q     <= mack_d;
    end
  end

endmodule

// File: tb/tb_i2c_pcf8574_target.sv
// Bench for i2c_pcf8574_target: an I2C master model on an open-drain bus plus a
// transaction-level model of the expected target behaviour.
module tb_i2c_pcf8574_target;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl_m = 1'b1;
  logic sda_low = 1'b0;
  wire  sda;

  pullup (sda);
  assign sda = sda_low ? 1'b0 : 1'bz;

  i2c_pcf8574_target_if io ();

  i2c_pcf8574_target dut (
    .clk   (clk),
    .reset (reset),
    .SCL   (scl_m),
    .SDA   (sda),
    .io    (io)
  );

  always #5 clk = ~clk;

  // Model state
  logic [7:0] m_port_out = 8'hFF;
  logic       m_busy = 1'b0;
  logic       m_live = 1'b0;
  logic       m_rw = 1'b0;
  logic [7:0] m_load = 8'h00;
  int         m_wr = 0;
  int         m_rd = 0;
  logic       exp_sda = 1'b1;
  logic       cond_active = 1'b1;

  int dut_wr = 0;
  int dut_rd = 0;
  int n_total = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Compare process: outputs are meaningful whenever SCL is high outside START/STOP/reset.
  always @(negedge clk) begin
    if (io.wr_tick) dut_wr++;
    if (io.rd_tick) dut_rd++;
    if (io.wr_tick || io.rd_tick)
      check("tick_exclusive", 32'(io.wr_tick & io.rd_tick), 32'd0);
    if (scl_m && !cond_active && !reset) begin
      check("port_out", 32'(io.port_out), 32'(m_port_out));
      check("busy", 32'(io.busy), 32'(m_busy));
      check("wr_tick_count", 32'(dut_wr), 32'(m_wr));
      check("rd_tick_count", 32'(dut_rd), 32'(m_rd));
      check("sda_level", 32'(sda), 32'(exp_sda));
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sda_low = !b;
    exp_sda = b;
    wait_clk(10);
    scl_m = 1'b1;
    wait_clk(20);
    scl_m = 1'b0;
    wait_clk(10);
  endtask

  task automatic recv_bit(input logic exp, output logic got);
    sda_low = 1'b0;
    exp_sda = exp;
    wait_clk(10);
    scl_m = 1'b1;
    wait_clk(10);
    got = sda;
    wait_clk(10);
    scl_m = 1'b0;
    wait_clk(10);
  endtask

  task automatic start_cond();
    cond_active = 1'b1;
    if (!scl_m) begin
      sda_low = 1'b0;
      wait_clk(10);
      scl_m = 1'b1;
      wait_clk(10);
    end
    sda_low = 1'b1;
    wait_clk(10);
    scl_m = 1'b0;
    wait_clk(10);
    m_busy = 1'b0;
    m_live = 1'b0;
    cond_active = 1'b0;
  endtask

  task automatic stop_cond();
    cond_active = 1'b1;
    sda_low = 1'b1;
    wait_clk(10);
    scl_m = 1'b1;
    wait_clk(10);
    sda_low = 1'b0;
    wait_clk(10);
    m_busy = 1'b0;
    m_live = 1'b0;
    exp_sda = 1'b1;
    cond_active = 1'b0;
  endtask

  // Master write of one byte; the model applies the target's rules once the 8 bits are out.
  task automatic wr_byte(input logic [7:0] b, input logic is_addr, output logic ack);
    logic exp_ack;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    if (is_addr) begin
      m_live = (b[7:1] == 7'h27);
      m_rw   = b[0];
      if (m_live) m_busy = 1'b1;
    end else if (m_live && !m_rw) begin
      m_port_out = b;
      m_wr++;
    end
    exp_ack = !(m_live && (is_addr || !m_rw));
    recv_bit(exp_ack, ack);
    if (is_addr && m_live && m_rw) begin
      m_load = io.port_in;
      m_rd++;
    end
  endtask

  // Master read of one byte followed by the master's ACK (0) or NACK (1).
  task automatic rd_byte(input logic mack, input logic [7:0] next_in, output logic [7:0] got);
    logic bit_v;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(m_live ? m_load[i] : 1'b1, bit_v);
      got[i] = bit_v;
    end
    io.port_in = next_in;
    send_bit(mack);
    if (m_live) begin
      if (!mack) begin
        m_load = io.port_in;
        m_rd++;
      end else begin
        m_live = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    cond_active = 1'b1;
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(2);
    m_port_out = 8'hFF;
    m_busy = 1'b0;
    m_live = 1'b0;
    exp_sda = 1'b1;
    cond_active = 1'b0;
  endtask

  logic       ack;
  logic [7:0] rb;
  int         wr_before, rd_before;

  initial begin
    io.port_in = 8'h00;
    do_reset();
    check("rst_port_out", 32'(io.port_out), 32'h0FF);
    check("rst_busy", 32'(io.busy), 32'd0);
    check("rst_wr_tick", 32'(io.wr_tick), 32'd0);
    check("rst_rd_tick", 32'(io.rd_tick), 32'd0);
    check("rst_sda", 32'(sda), 32'd1);
    check("rst_state", 32'(io.dbg_state), 32'd0);
    wait_clk(20);

    // Address mismatch: no ACK anywhere, nothing changes.
    start_cond();
    wr_byte(8'h40, 1'b1, ack);
    check("mis_addr_nack", 32'(ack), 32'd1);
    wr_byte(8'h00, 1'b0, ack);
    check("mis_data_nack", 32'(ack), 32'd1);
    stop_cond();
    wait_clk(20);
    check("mis_port_out", 32'(io.port_out), 32'h0FF);
    check("mis_ticks", 32'(dut_wr + dut_rd), 32'd0);

    // Write 8'hA5.
    start_cond();
    wr_byte(8'h4E, 1'b1, ack);
    check("wr_addr_ack", 32'(ack), 32'd0);
    wr_byte(8'hA5, 1'b0, ack);
    check("wr_data_ack", 32'(ack), 32'd0);
    check("wr_busy_mid", 32'(io.busy), 32'd1);
    stop_cond();
    wait_clk(20);
    check("wr_port_out", 32'(io.port_out), 32'h0A5);
    check("wr_one_tick", 32'(dut_wr), 32'd1);
    check("wr_busy_after", 32'(io.busy), 32'd0);

    // Read port_in=8'h3C, master NACK.
    io.port_in = 8'h3C;
    start_cond();
    wr_byte(8'h4F, 1'b1, ack);
    check("rd_addr_ack", 32'(ack), 32'd0);
    rd_byte(1'b1, 8'h3C, rb);
    check("rd_byte", 32'(rb), 32'h03C);
    stop_cond();
    wait_clk(20);
    check("rd_one_tick", 32'(dut_rd), 32'd1);

    // Write 8'h12, repeated START, read 8'h81 (ACK) then 8'h7E (NACK).
    start_cond();
    wr_byte(8'h4E, 1'b1, ack);
    wr_byte(8'h12, 1'b0, ack);
    io.port_in = 8'h81;
    start_cond();
    wr_byte(8'h4F, 1'b1, ack);
    check("sr_addr_ack", 32'(ack), 32'd0);
    rd_byte(1'b0, 8'h7E, rb);
    check("sr_rd0", 32'(rb), 32'h081);
    rd_byte(1'b1, 8'h7E, rb);
    check("sr_rd1", 32'(rb), 32'h07E);
    stop_cond();
    wait_clk(20);
    check("sr_port_out", 32'(io.port_out), 32'h012);
    check("sr_rd_ticks", 32'(dut_rd), 32'd3);

    // Abort after 4 data bits, then a full write of 8'h55.
    wr_before = dut_wr;
    start_cond();
    wr_byte(8'h4E, 1'b1, ack);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    stop_cond();
    wait_clk(20);
    check("abort_port_out", 32'(io.port_out), 32'h012);
    check("abort_no_tick", 32'(dut_wr - wr_before), 32'd0);
    check("abort_state_idle", 32'(io.dbg_state), 32'd0);
    start_cond();
    wr_byte(8'h4E, 1'b1, ack);
    wr_byte(8'h55, 1'b0, ack);
    check("abort_next_ack", 32'(ack), 32'd0);
    stop_cond();
    wait_clk(20);
    check("abort_next_port_out", 32'(io.port_out), 32'h055);

    // Reset while the target drives a 0 (MSB of 8'h3C).
    io.port_in = 8'h3C;
    rd_before = dut_rd;
    start_cond();
    wr_byte(8'h4F, 1'b1, ack);
    check("rr_msb_driven", 32'(sda), 32'd0);
    cond_active = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rr_sda_released", 32'(sda), 32'd1);
    wait_clk(2);
    reset = 1'b0;
    wait_clk(1);
    m_port_out = 8'hFF;
    m_busy = 1'b0;
    m_live = 1'b0;
    cond_active = 1'b0;
    check("rr_port_out", 32'(io.port_out), 32'h0FF);
    rd_byte(1'b1, 8'h3C, rb);
    check("rr_ignored_bits", 32'(rb), 32'h0FF);
    stop_cond();
    wait_clk(20);
    check("rr_rd_ticks", 32'(dut_rd - rd_before), 32'd1);
    check("rr_busy", 32'(io.busy), 32'd0);
    start_cond();
    wr_byte(8'h4E, 1'b1, ack);
    wr_byte(8'h99, 1'b0, ack);
    stop_cond();
    wait_clk(20);
    check("rr_resume_port_out", 32'(io.port_out), 32'h099);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
